// File: rtl/btn_set_pkg.sv
// Shared encodings and default timing constants for the watch time-set button controller.
package btn_set_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } mode_e;

  localparam int unsigned DEF_TICK_DIV     = 100000;
  localparam int unsigned DEF_LONG_TICKS   = 1000;
  localparam int unsigned DEF_REPEAT_TICKS = 200;
  localparam int unsigned DEF_BLINK_TICKS  = 250;
  localparam int unsigned DEF_IDLE_TICKS   = 10000;

  // Field order stepped by a short mode press; RUN is left alone.
  function automatic mode_e next_field(input mode_e m);
    case (m)
      MODE_SET_HH: return MODE_SET_MM;
      MODE_SET_MM: return MODE_SET_SS;
      MODE_SET_SS: return MODE_SET_HH;
      default:     return m;
    endcase
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Per-key edge detection, short/long press classification and auto-repeat
// for one debounced key level.
module key_hold_timer
  import btn_set_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key,
  input  logic rep_en,
  output logic rise,
  output logic fall,
  output logic short_evt,
  output logic long_evt,
  output logic rep_evt
);

  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);

  logic              prev_q, prev_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic [REP_W-1:0]  rep_q, rep_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    prev_d      = key;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    rep_d       = rep_q;
    long_evt    = 1'b0;
    rep_evt     = 1'b0;

    rise      = key & ~prev_q;
    fall      = ~key & prev_q;
    short_evt = fall & ~long_done_q;

    if (rise) begin
      hold_d = '0;
    end else if (key && tick && (hold_q < HOLD_W'(LONG_TICKS))) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HOLD_W'(LONG_TICKS - 1)) begin
        long_evt    = 1'b1;
        long_done_d = 1'b1;
      end
    end

    // The long flag must survive until the fall cycle so short_evt can see it.
    if (fall) begin
      long_done_d = 1'b0;
    end

    if (!key) begin
      rep_d = '0;
    end else if (long_done_q && tick && rep_en) begin
      if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
        rep_d   = '0;
        rep_evt = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and clear on the
  // asynchronous active-low reset, independent of the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= 1'b0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      rep_q       <= '0;
    end else begin
      prev_q      <= prev_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      rep_q       <= rep_d;
    end
  end

endmodule

// File: rtl/btn_set_ctrl.sv
// Time-set button sequencer: prescaler, mode FSM, idle timeout, blink and
// inc/dec arbitration on top of three key_hold_timer instances.
module btn_set_ctrl
  import btn_set_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned BLINK_TICKS  = DEF_BLINK_TICKS,
  parameter int unsigned IDLE_TICKS   = DEF_IDLE_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_dn,
  output logic [1:0] mode,
  output logic       inc,
  output logic       dec,
  output logic       blink
);

  localparam int unsigned PRE_W   = $clog2(TICK_DIV + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned IDLE_W  = $clog2(IDLE_TICKS + 1);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  mode_e              mode_q, mode_d;
  logic               blink_q, blink_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;

  logic tick;
  logic in_set, mode_chg, both_adj, any_edge, idle_expire, adj_ok;

  logic m_rise, m_fall, m_short, m_long, m_rep;
  logic u_rise, u_fall, u_short, u_long, u_rep;
  logic d_rise, d_fall, d_short, d_long, d_rep;

  // Holding both adjust keys freezes their repeat counters.
  assign both_adj = key_up & key_dn;

  key_hold_timer #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_key_mode (
    .clk(clk), .rst(rst), .tick(tick), .key(key_mode), .rep_en(1'b0),
    .rise(m_rise), .fall(m_fall), .short_evt(m_short), .long_evt(m_long), .rep_evt(m_rep)
  );

  key_hold_timer #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_key_up (
    .clk(clk), .rst(rst), .tick(tick), .key(key_up), .rep_en(~both_adj),
    .rise(u_rise), .fall(u_fall), .short_evt(u_short), .long_evt(u_long), .rep_evt(u_rep)
  );

  key_hold_timer #(.LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)) u_key_dn (
    .clk(clk), .rst(rst), .tick(tick), .key(key_dn), .rep_en(~both_adj),
    .rise(d_rise), .fall(d_fall), .short_evt(d_short), .long_evt(d_long), .rep_evt(d_rep)
  );

  logic unused_evts;
  assign unused_evts = &{1'b0, m_rep, u_short, d_short};

  always_comb begin
    tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;

    in_set      = (mode_q != MODE_RUN);
    any_edge    = m_rise | m_fall | u_rise | u_fall | d_rise | d_fall;
    idle_expire = in_set && tick && !any_edge && (idle_q == IDLE_W'(IDLE_TICKS - 1));

    mode_d = mode_q;
    if (m_long) begin
      mode_d = in_set ? MODE_RUN : MODE_SET_HH;
    end else if (m_short && in_set) begin
      mode_d = next_field(mode_q);
    end else if (idle_expire) begin
      mode_d = MODE_RUN;
    end
    mode_chg = (mode_d != mode_q);

    idle_d = idle_q;
    if (!in_set || mode_chg || any_edge) begin
      idle_d = '0;
    end else if (tick) begin
      idle_d = idle_q + 1'b1;
    end

    // A mode change in the same cycle takes precedence over any adjust event.
    adj_ok = in_set && !mode_chg && !both_adj;
    inc_d  = adj_ok && (u_rise || u_long || u_rep);
    dec_d  = adj_ok && (d_rise || d_long || d_rep);

    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (!in_set || mode_chg || key_up || key_dn) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      bcnt_q  <= '0;
      idle_q  <= '0;
      mode_q  <= MODE_RUN;
      blink_q <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      bcnt_q  <= bcnt_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
      blink_q <= blink_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign mode  = mode_q;
  assign inc   = inc_q;
  assign dec   = dec_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_btn_set_ctrl.sv
// Scoreboard bench for btn_set_ctrl: stimulus queues expected mode/inc/dec
// events with the edge they must appear on; a monitor pops and compares.
`timescale 1ns/1ps
module tb_btn_set_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 5;
  localparam int REPEAT_TICKS = 3;
  localparam int BLINK_TICKS  = 2;
  localparam int IDLE_TICKS   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_up = 1'b0;
  logic       key_dn = 1'b0;
  logic [1:0] mode;
  logic       inc, dec, blink;

  btn_set_ctrl #(
    .TICK_DIV(TICK_DIV), .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS),
    .BLINK_TICKS(BLINK_TICKS), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_dn(key_dn),
    .mode(mode), .inc(inc), .dec(dec), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_MODE, EV_INC, EV_DEC} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
    int       edge_no;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  ecnt    = 0;

  // Clock edges since reset release; ticks take effect on multiples of TICK_DIV.
  always @(posedge clk or negedge rst) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, ecnt);
    end
  endtask

  function automatic void expect_ev(input ev_kind_e k, input int v, input int e);
    ev_t ev;
    ev.kind    = k;
    ev.val     = v;
    ev.edge_no = e;
    exp_q.push_back(ev);
  endfunction

  // Edge on which the k-th tick strictly after edge r takes effect.
  function automatic int tick_after(input int r, input int k);
    return (r / TICK_DIV + 1) * TICK_DIV + (k - 1) * TICK_DIV;
  endfunction

  task automatic observe(input ev_kind_e k, input int v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s=%0d at edge %0d, expected none", k.name(), v, ecnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.edge_no != ecnt) begin
        n_fail++;
        $display("FAIL event_order: got %s=%0d at edge %0d, expected %s=%0d at edge %0d",
                 k.name(), v, ecnt, e.kind.name(), e.val, e.edge_no);
      end
    end
  endtask

  initial begin : monitor
    logic [1:0] last_mode;
    ev_t        lost;
    last_mode = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_mode = 2'd0;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].edge_no < ecnt) begin
        lost = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: got nothing by edge %0d, expected %s=%0d at edge %0d",
                 ecnt, lost.kind.name(), lost.val, lost.edge_no);
      end
      if (mode !== last_mode) begin
        observe(EV_MODE, int'(mode));
        last_mode = mode;
      end
      if (inc !== 1'b0) observe(EV_INC, 1);
      if (dec !== 1'b0) observe(EV_DEC, 1);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected finish within 1 ms");
    $fatal(1);
  end

  initial begin : stimulus
    int r, f, g, tidle;
    bit seen_blink;
    int short_seq [4] = '{2, 3, 1, 2};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({mode, inc, dec, blink}), 32'd0);
    rst = 1'b1;

    // Quiet RUN after reset.
    repeat (200) begin
      @(negedge clk);
      check("run_quiet_outputs", 32'({mode, inc, dec, blink}), 32'd0);
    end

    // Up in RUN is ignored; long mode enters SET_HH.
    key_up = 1'b1;
    repeat (100) @(negedge clk);
    key_up = 1'b0;
    repeat (4) @(negedge clk);
    check("run_ignores_up", 32'(mode), 32'd0);

    r = ecnt + 1;
    expect_ev(EV_MODE, 1, tick_after(r, LONG_TICKS));
    key_mode = 1'b1;
    repeat (30) @(negedge clk);
    key_mode = 1'b0;
    repeat (6) @(negedge clk);
    check("long_mode_holds_set_hh", 32'(mode), 32'd1);

    // Short mode presses cycle the field, ending on SET_MM.
    for (int i = 0; i < 4; i++) begin
      r = ecnt + 1;
      expect_ev(EV_MODE, short_seq[i], r + 8);
      key_mode = 1'b1;
      repeat (8) @(negedge clk);
      key_mode = 1'b0;
      repeat (4) @(negedge clk);
      check("short_mode_step", 32'(mode), 32'(short_seq[i]));
    end

    // Up held in SET_MM: inc on rise, at long press, then every REPEAT_TICKS.
    r = ecnt + 1;
    expect_ev(EV_INC, 1, r);
    for (int x = tick_after(r, LONG_TICKS); x <= r + 59; x += REPEAT_TICKS * TICK_DIV)
      expect_ev(EV_INC, 1, x);
    key_up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("blink_off_while_up", 32'(blink), 32'd0);
    end
    key_up = 1'b0;
    repeat (4) @(negedge clk);

    // Both adjust keys held: nothing issued.
    key_up = 1'b1;
    key_dn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("blink_off_while_both", 32'(blink), 32'd0);
    end
    key_up = 1'b0;
    key_dn = 1'b0;
    repeat (4) @(negedge clk);
    check("both_held_mode_kept", 32'(mode), 32'd2);

    // Mode short press falls in the same cycle as an up rise: mode wins.
    key_mode = 1'b1;
    repeat (8) @(negedge clk);
    f = ecnt + 1;
    expect_ev(EV_MODE, 3, f);
    key_mode = 1'b0;
    key_up   = 1'b1;
    repeat (6) @(negedge clk);
    g = ecnt + 1;
    key_up = 1'b0;

    // Idle timeout from SET_SS back to RUN.
    tidle = tick_after(g, IDLE_TICKS);
    expect_ev(EV_MODE, 0, tidle);
    seen_blink = 1'b0;
    while (ecnt < tidle) begin
      @(negedge clk);
      if (blink === 1'b1) seen_blink = 1'b1;
    end
    check("blink_toggles_in_set", 32'(seen_blink), 32'd1);
    check("idle_returns_run", 32'(mode), 32'd0);
    check("blink_off_after_idle", 32'(blink), 32'd0);

    // Asynchronous reset in the middle of an up press in SET_HH.
    r = ecnt + 1;
    expect_ev(EV_MODE, 1, tick_after(r, LONG_TICKS));
    key_mode = 1'b1;
    repeat (30) @(negedge clk);
    key_mode = 1'b0;
    repeat (4) @(negedge clk);
    r = ecnt + 1;
    expect_ev(EV_INC, 1, r);
    key_up = 1'b1;
    @(negedge clk);
    #1;
    check("inc_before_reset", 32'(inc), 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'({mode, inc, dec, blink}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("run_after_reset_held_up", 32'({mode, inc, dec, blink}), 32'd0);
    key_up = 1'b0;
    repeat (5) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
